// File: rtl/clk_div_prog_if.sv
// Config port of clk_div_prog: valid/ready request carrying channel, divisor and high time,
// plus the one-cycle reject pulse.
interface clk_div_prog_if #(
  parameter int NCH = 2,
  parameter int CW  = 28
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [CW-1:0]  cfg_high;
  logic           cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with glitch-free, period-boundary config updates.
// Optional PHASE_ALIGN_EN adds sync_all to restart every channel's period together.
module clk_div_chan #(
  parameter int CW      = 28,
  parameter int DEF_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  input  logic [CW-1:0] wr_high,
  output logic          pend,
  output logic          clk_out,
  output logic          tick
);
  logic [CW-1:0] cnt, div_act, high_act, div_sh, high_sh;
  logic [CW-1:0] cnt_n, div_n, high_n;
  logic          wrap, apply;

  always_comb begin
    wrap   = en & (cnt == div_act - CW'(1));
    // pend is only set when clear, so a same-cycle write never applies at this wrap
    apply  = pend & (~en | wrap | sync);
    div_n  = apply ? div_sh  : div_act;
    high_n = apply ? high_sh : high_act;
    cnt_n  = (en & ~sync & ~wrap) ? cnt + CW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= CW'(DEF_DIV);
      high_act <= CW'(DEF_DIV / 2);
      div_sh   <= '0;
      high_sh  <= '0;
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_act  <= div_n;
      high_act <= high_n;
      if (wr) begin
        div_sh  <= wr_div;
        high_sh <= wr_high;
      end
      pend     <= wr | (pend & ~apply);
      // outputs follow the next-state counter so they line up with cnt
      clk_out  <= en & (cnt_n >= div_n - high_n);
      tick     <= en & ~sync & (cnt_n == div_n - CW'(1));
    end
  end
endmodule

module clk_div_prog #(
  parameter int NCH     = 2,
  parameter int CW      = 28,
  parameter int DEF_DIV = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] en,
  clk_div_prog_if.slave  cfg,
`ifdef PHASE_ALIGN_EN
  input  logic           sync_all,
`endif
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] pend, wr;
  logic           sync, ch_ok, err_req, err_q;
  logic [CW-1:0]  high_cl;

`ifdef PHASE_ALIGN_EN
  assign sync = sync_all;
`else
  assign sync = 1'b0;
`endif

  always_comb begin
    ch_ok         = int'(cfg.cfg_ch) < NCH;
    err_req       = cfg.cfg_valid & (~ch_ok | (cfg.cfg_div == '0));
    cfg.cfg_ready = 1'b1;
    wr            = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) begin
        cfg.cfg_ready = ~pend[i];
        wr[i]         = cfg.cfg_valid & ~err_req & ~pend[i];
      end
    end
    // out-of-range high time falls back to a ~50% duty cycle
    if ((cfg.cfg_high == '0) || (cfg.cfg_high >= cfg.cfg_div))
      high_cl = (cfg.cfg_div == CW'(1)) ? CW'(1) : (cfg.cfg_div >> 1);
    else
      high_cl = cfg.cfg_high;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_req;
  end
  assign cfg.cfg_err = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(.CW(CW), .DEF_DIV(DEF_DIV)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg.cfg_div),
      .wr_high (high_cl),
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: an integer reference model predicts outputs each clock,
// a negedge monitor compares them with the DUT.
module tb_clk_div_prog;
  localparam int NCH = 3, CW = 8, DEF_DIV = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           sync_all = 1'b0;
  logic [NCH-1:0] clk_out, tick;

  clk_div_prog_if #(.NCH(NCH), .CW(CW)) cfg ();

  clk_div_prog #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg.slave),
`ifdef PHASE_ALIGN_EN
    .sync_all(sync_all),
`endif
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] co;
    logic [NCH-1:0] tk;
    logic           err;
  } exp_t;

  exp_t q[$];
  int   nvec = 0, nfail = 0;

  // reference state: position in period, active period/high, shadow request
  int m_cnt[NCH], m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH];
  bit m_pend[NCH];

  exp_t me;
  int   acc, d, h;
  bit   err, wrapped;

  always @(posedge clk) begin
    me.co = '0; me.tk = '0; me.err = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_div[i] = DEF_DIV; m_high[i] = DEF_DIV / 2; m_pend[i] = 0;
      end
    end else begin
      err = cfg.cfg_valid && (cfg.cfg_div == 0 || int'(cfg.cfg_ch) >= NCH);
      acc = -1;
      if (cfg.cfg_valid && !err && !m_pend[cfg.cfg_ch]) acc = int'(cfg.cfg_ch);
      me.err = err;
      for (int i = 0; i < NCH; i++) begin
        wrapped = en[i] && (m_cnt[i] == m_div[i] - 1);
        if (m_pend[i] && (!en[i] || wrapped || sync_all)) begin
          m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
        end
        if (!en[i] || sync_all || wrapped) m_cnt[i] = 0;
        else                               m_cnt[i] = m_cnt[i] + 1;
        if (en[i]) begin
          me.co[i] = (m_cnt[i] >= m_div[i] - m_high[i]);
          me.tk[i] = !sync_all && (m_cnt[i] == m_div[i] - 1);
        end
      end
      if (acc >= 0) begin
        d = int'(cfg.cfg_div); h = int'(cfg.cfg_high);
        m_pend[acc] = 1; m_sdiv[acc] = d;
        m_shigh[acc] = (h == 0 || h >= d) ? ((d == 1) ? 1 : d / 2) : h;
      end
    end
    q.push_back(me);
  end

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  exp_t mo;
  int   c;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mo = q.pop_front();
      chk("clk_out", int'(clk_out), int'(mo.co));
      chk("tick", int'(tick), int'(mo.tk));
      chk("cfg_err", int'(cfg.cfg_err), int'(mo.err));
      c = int'(cfg.cfg_ch);
      chk("cfg_ready", int'(cfg.cfg_ready), (c >= NCH) ? 1 : int'(!m_pend[c]));
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic req(int ch, int dv, int hi);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = ch[1:0];
    cfg.cfg_div   = dv[CW-1:0];
    cfg.cfg_high  = hi[CW-1:0];
    cyc();
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_div = '0; cfg.cfg_high = '0;
    cyc(3);
    rst_n = 1'b1; en = 3'b001;
    cyc(8);
    cyc(1); req(0, 5, 2); cyc(12);
    req(0, 4, 0); cyc(10);
    req(0, 6, 9); cyc(14);
    req(0, 0, 3); cyc(2);
    req(3, 4, 1); cyc(3);
    req(0, 5, 2); cyc(8);
    en = 3'b000; cyc(3);
    en = 3'b001; cyc(12);
    req(1, 1, 0); en = 3'b011; cyc(6);
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(5);
`ifdef PHASE_ALIGN_EN
    req(0, 3, 0); req(1, 7, 0); en = 3'b011; cyc(5);
    sync_all = 1'b1; cyc(); sync_all = 1'b0; cyc(45);
`endif
    en = NCH'($urandom_range(0, 7));
    for (int k = 0; k < 3000; k++) begin
      cfg.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg.cfg_ch    = 2'($urandom_range(0, 3));
      cfg.cfg_div   = CW'($urandom_range(0, 9));
      cfg.cfg_high  = CW'($urandom_range(0, 10));
      if ($urandom_range(0, 49) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      rst_n = ($urandom_range(0, 299) != 0);
`ifdef PHASE_ALIGN_EN
      sync_all = ($urandom_range(0, 39) == 0);
`endif
      cyc();
    end
    cfg.cfg_valid = 1'b0; rst_n = 1'b1; sync_all = 1'b0;
    cyc(4);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      nvec++; nfail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
